// File: rtl/pcounter_mod.sv
// Programmable-modulus up/down counter with wrap/saturate/one-shot terminal modes; registered out, 1-cycle step latency.
// No backpressure: en gates stepping, clr > load > en step > hold.
module pcounter_mod #(
   parameter int WIDTH     = 4,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             r,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] mod_val,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap,
   output logic             done
);

   localparam logic [WIDTH-1:0] RST_OUT = WIDTH'(RESET_VAL);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_d;
   logic             wrap_d;
   logic             one_shot;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_clamped;

   assign one_shot     = (mode == 2'b10);
   // Up-terminal uses >= so a lowered mod_val below out is still terminal.
   assign tc           = up ? (out >= mod_val) : (out == '0);
   assign step_val     = up ? (out + WIDTH'(1)) : (out - WIDTH'(1));
   assign load_clamped = (load_val > mod_val) ? mod_val : load_val;
   assign done         = (state_q == ST_DONE);

   always_comb begin
      out_d   = out;
      wrap_d  = 1'b0;
      state_d = one_shot ? state_q : ST_IDLE;
      if (clr) begin
         out_d   = '0;
         state_d = ST_IDLE;
      end else if (load) begin
         out_d   = load_clamped;
         state_d = one_shot ? ST_RUN : ST_IDLE;
      end else if (en) begin
         if (one_shot) begin
            if (state_q == ST_RUN) begin
               if (!tc) out_d = step_val;
               else     state_d = ST_DONE;
            end
         end else if (!tc) begin
            out_d = step_val;
         end else if (mode == 2'b01) begin
            if (up && (out > mod_val)) out_d = mod_val;
         end else begin
            // Wrap against mod_val rather than 2^WIDTH.
            out_d  = up ? '0 : mod_val;
            wrap_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         out     <= RST_OUT;
         wrap    <= 1'b0;
         state_q <= ST_IDLE;
      end else begin
         out     <= out_d;
         wrap    <= wrap_d;
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_pcounter_mod.sv
// Bench for pcounter_mod: vector table, directed corner sequences, width sweep and randomized run vs a reference model.
module tb_pcounter_mod;

   logic       clk;
   logic       r;
   logic       clr, load, en, up;
   logic [3:0] load_val, mod_val;
   logic [1:0] mode;
   logic [3:0] out4;
   logic       tc4, wrap4, done4;
   logic [1:0] lv2, mv2, out2;
   logic       tc2, wrap2, done2;
   logic [5:0] lv6, mv6, out6;
   logic       tc6, wrap6, done6;

   int total_cnt = 0;
   int pass_cnt  = 0;

   int m_out;
   bit m_wrap, m_done, m_run;

   pcounter_mod #(.WIDTH(4), .RESET_VAL(0)) dut (
      .clk(clk), .r(r), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
      .mod_val(mod_val), .mode(mode), .out(out4), .tc(tc4), .wrap(wrap4), .done(done4));

   pcounter_mod #(.WIDTH(2), .RESET_VAL(0)) dut2 (
      .clk(clk), .r(r), .clr(clr), .load(load), .load_val(lv2), .en(en), .up(up),
      .mod_val(mv2), .mode(mode), .out(out2), .tc(tc2), .wrap(wrap2), .done(done2));

   pcounter_mod #(.WIDTH(6), .RESET_VAL(0)) dut6 (
      .clk(clk), .r(r), .clr(clr), .load(load), .load_val(lv6), .en(en), .up(up),
      .mod_val(mv6), .mode(mode), .out(out6), .tc(tc6), .wrap(wrap6), .done(done6));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit clr, load;
      int lv;
      bit en, up;
      int mv, md, eo;
      bit et, ew, ed;
   } vec_t;

   vec_t tbl[21];

   function automatic vec_t mk(input bit c, input bit l, input int lv, input bit e, input bit u,
                               input int mv, input int md, input int eo,
                               input bit et, input bit ew, input bit ed);
      vec_t v;
      v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u;
      v.mv = mv; v.md = md; v.eo = eo; v.et = et; v.ew = ew; v.ed = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      else pass_cnt++;
   endtask

   // Reference: counter as an integer, one-shot as an armed/done flag pair.
   task automatic model_reset();
      m_out = 0; m_wrap = 0; m_done = 0; m_run = 0;
   endtask

   function automatic bit model_tc();
      return up ? (m_out >= int'(mod_val)) : (m_out == 0);
   endfunction

   task automatic model_edge();
      int mv;
      bit t;
      mv = int'(mod_val);
      t  = model_tc();
      m_wrap = 0;
      if (mode != 2'b10) begin m_run = 0; m_done = 0; end
      if (clr) begin
         m_out = 0; m_run = 0; m_done = 0;
      end else if (load) begin
         m_out = (int'(load_val) < mv) ? int'(load_val) : mv;
         m_done = 0;
         m_run = (mode == 2'b10);
      end else if (en) begin
         if (mode == 2'b10) begin
            if (m_run) begin
               if (!t) m_out += up ? 1 : -1;
               else begin m_run = 0; m_done = 1; end
            end
         end else if (!t) m_out += up ? 1 : -1;
         else if (mode == 2'b01) begin
            if (up && m_out > mv) m_out = mv;
         end else begin
            m_out = up ? 0 : mv;
            m_wrap = 1;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string nm);
      chk({nm, "_out"},  out4,  m_out);
      chk({nm, "_tc"},   tc4,   model_tc());
      chk({nm, "_wrap"}, wrap4, m_wrap);
      chk({nm, "_done"}, done4, m_done);
   endtask

   task automatic set_in(input bit c, input bit l, input int lv, input bit e, input bit u,
                         input int mv, input int md);
      clr = c; load = l; load_val = 4'(lv); en = e; up = u; mod_val = 4'(mv); mode = 2'(md);
   endtask

   initial begin
      tbl[0]  = mk(1,1, 5,1,1, 9,0,  0,0,0,0);
      tbl[1]  = mk(0,1,14,0,1, 7,0,  7,1,0,0);
      tbl[2]  = mk(0,0, 0,1,1, 7,0,  0,0,1,0);
      tbl[3]  = mk(0,0, 0,1,0, 7,0,  7,0,1,0);
      tbl[4]  = mk(0,1,10,0,1,15,0, 10,0,0,0);
      tbl[5]  = mk(0,0, 0,1,1, 4,0,  0,0,1,0);
      tbl[6]  = mk(0,0, 0,0,1, 4,0,  0,0,0,0);
      tbl[7]  = mk(0,1,12,0,1,12,1, 12,1,0,0);
      tbl[8]  = mk(0,0, 0,1,1,12,1, 12,1,0,0);
      tbl[9]  = mk(0,0, 0,1,1,10,1, 10,1,0,0);
      tbl[10] = mk(0,0, 0,1,0,10,1,  9,0,0,0);
      tbl[11] = mk(0,0, 0,1,1,10,2,  9,0,0,0);
      tbl[12] = mk(0,1, 9,0,1,10,2,  9,0,0,0);
      tbl[13] = mk(0,0, 0,1,1,10,2, 10,1,0,0);
      tbl[14] = mk(0,0, 0,1,1,10,2, 10,1,0,1);
      tbl[15] = mk(0,0, 0,1,1,10,2, 10,1,0,1);
      tbl[16] = mk(0,0, 0,0,1,10,0, 10,1,0,0);
      tbl[17] = mk(0,0, 0,1,1,10,2, 10,1,0,0);
      tbl[18] = mk(0,1, 5,0,1, 0,0,  0,1,0,0);
      tbl[19] = mk(0,0, 0,1,1, 0,0,  0,1,1,0);
      tbl[20] = mk(0,0, 0,1,0, 0,0,  0,1,1,0);

      lv2 = '0; mv2 = '1; lv6 = '0; mv6 = '1;
      set_in(0,0,0,0,1,15,0);
      r = 1'b1;
      model_reset();

      // Asynchronous reset, no clock edge required.
      #1 r = 1'b0;
      #1;
      chk("rst0_out", out4, 0);
      chk("rst0_wrap", wrap4, 0);
      chk("rst0_done", done4, 0);
      @(negedge clk);
      r = 1'b1;
      set_in(0,0,0,1,1,15,0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("pre_rst_cnt", out4, i);
      end
      #3 r = 1'b0;
      #1;
      chk("midrst_out", out4, 0);
      chk("midrst_wrap", wrap4, 0);
      chk("midrst_done", done4, 0);
      model_reset();
      @(negedge clk);
      r = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("post_rst_cnt", out4, i);
      end

      foreach (tbl[k]) begin
         set_in(tbl[k].clr, tbl[k].load, tbl[k].lv, tbl[k].en, tbl[k].up, tbl[k].mv, tbl[k].md);
         tick();
         chk($sformatf("vec%0d_out", k),  out4,  tbl[k].eo);
         chk($sformatf("vec%0d_tc", k),   tc4,   tbl[k].et);
         chk($sformatf("vec%0d_wrap", k), wrap4, tbl[k].ew);
         chk($sformatf("vec%0d_done", k), done4, tbl[k].ed);
      end

      // Wrap mode 0..9 then back to 0, then down-wrap from 0.
      set_in(1,0,0,0,1,9,0); tick();
      set_in(0,0,0,1,1,9,0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("wrapup_out", out4, i % 10);
         chk("wrapup_wrap", wrap4, i == 10);
         chk("wrapup_tc", tc4, (i % 10) == 9);
      end
      up = 1'b0; tick();
      chk("wrapdn_out", out4, 9);
      chk("wrapdn_wrap", wrap4, 1);

      // Saturate up to 12, then down to 0 and hold.
      set_in(1,0,0,0,1,12,1); tick();
      set_in(0,0,0,1,1,12,1);
      for (int i = 1; i <= 14; i++) begin
         tick();
         chk("satup_out", out4, (i < 12) ? i : 12);
         chk("satup_wrap", wrap4, 0);
         chk("satup_tc", tc4, i >= 12);
      end
      up = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         tick();
         chk("satdn_out", out4, (i < 12) ? 12 - i : 0);
         chk("satdn_wrap", wrap4, 0);
      end

      // One-shot: load 3, run to 6, done, re-arm with load 0.
      set_in(0,1,3,1,1,6,2); tick();
      chk("os_load_out", out4, 3);
      chk("os_load_done", done4, 0);
      load = 1'b0;
      for (int i = 4; i <= 6; i++) begin
         tick();
         chk("os_run_out", out4, i);
         chk("os_run_done", done4, 0);
      end
      chk("os_run_tc", tc4, 1);
      tick();
      chk("os_fin_out", out4, 6);
      chk("os_fin_done", done4, 1);
      chk("os_fin_wrap", wrap4, 0);
      tick();
      chk("os_hold_out", out4, 6);
      chk("os_hold_done", done4, 1);
      set_in(0,1,0,1,1,6,2); tick();
      chk("os_rearm_out", out4, 0);
      chk("os_rearm_done", done4, 0);
      load = 1'b0; tick();
      chk("os_restart_out", out4, 1);

      // Width sweep, all counters at full-scale modulus.
      set_in(1,0,0,0,1,15,0); tick();
      set_in(0,0,0,1,1,15,0);
      for (int i = 1; i <= 70; i++) begin
         tick();
         chk("sw2_out", out2, i % 4);
         chk("sw2_wrap", wrap2, (i % 4) == 0);
         chk("sw2_tc", tc2, (i % 4) == 3);
         chk("sw4_out", out4, i % 16);
         chk("sw4_wrap", wrap4, (i % 16) == 0);
         chk("sw6_out", out6, i % 64);
         chk("sw6_wrap", wrap6, (i % 64) == 0);
         chk("sw6_tc", tc6, (i % 64) == 63);
      end
      chk("sw2_done", done2, 0);
      chk("sw6_done", done6, 0);

      // Randomized run against the reference model.
      for (int i = 0; i < 1500; i++) begin
         clr  = ($urandom_range(0, 24) == 0);
         load = ($urandom_range(0, 9) == 0);
         load_val = 4'($urandom_range(0, 15));
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) up = ~up;
         if ($urandom_range(0, 15) == 0) mod_val = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
         tick();
         check_model("rand");
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
